// File: rtl/reg_file_port_ctrl.sv
// reg_file_port_ctrl: initiator side of the 32x16 register file.
// Time-multiplexes reg_file's shared port-1 index bus between operand
// reads from decode and write-backs buffered in a small in-order FIFO.
// Read-after-write hazards against buffered writes either stall the read
// or, with RFPC_WB_BYPASS_EN defined, forward from the youngest match.
module reg_file_port_ctrl #(
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 5,
  parameter int WB_DEPTH = 4,
  localparam int PTR_W   = $clog2(WB_DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [IDX_W-1:0]  rd_idx_a,
  input  logic [IDX_W-1:0]  rd_idx_b,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  wb_count,
  output logic [IDX_W-1:0]  rf_index1,
  output logic [IDX_W-1:0]  rf_index2,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              rf_w_enable,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  logic [WB_DEPTH-1:0][IDX_W-1:0]  fifo_idx_q;
  logic [WB_DEPTH-1:0][DATA_W-1:0] fifo_data_q;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_valid_q;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;

  logic full, empty, push, pop;
  logic hit_a, hit_b;
  logic rd_go, wr_go;
`ifdef RFPC_WB_BYPASS_EN
  logic [DATA_W-1:0] fwd_a, fwd_b;
`endif

  assign full     = (cnt_q == CNT_W'(WB_DEPTH));
  assign empty    = (cnt_q == '0);
  // Registered count only: a pop this cycle does not reopen wb_ready.
  assign wb_ready = rst_n && !full;
  assign wb_count = cnt_q;
  assign push     = wb_valid && wb_ready;
  assign pop      = wr_go;

  // Match read indices against live entries, walking oldest to youngest so
  // the last hit seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] pos;
    hit_a = 1'b0;
    hit_b = 1'b0;
`ifdef RFPC_WB_BYPASS_EN
    fwd_a = '0;
    fwd_b = '0;
`endif
    for (int k = 0; k < WB_DEPTH; k++) begin
      pos = rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < cnt_q) begin
        if (fifo_idx_q[pos] == rd_idx_a) begin
          hit_a = 1'b1;
`ifdef RFPC_WB_BYPASS_EN
          fwd_a = fifo_data_q[pos];
`endif
        end
        if (fifo_idx_q[pos] == rd_idx_b) begin
          hit_b = 1'b1;
`ifdef RFPC_WB_BYPASS_EN
          fwd_b = fifo_data_q[pos];
`endif
        end
      end
    end
  end

  // Slot arbitration: full FIFO forces a write, then reads, then draining.
  always_comb begin
`ifdef RFPC_WB_BYPASS_EN
    rd_go = rd_valid && !full;
`else
    rd_go = rd_valid && !full && !(hit_a || hit_b);
`endif
    wr_go = !rd_go && !empty;
  end

  // Drive the shared reg_file bus for the chosen slot; zero when idle.
  always_comb begin
    rd_ready    = 1'b0;
    rf_index1   = '0;
    rf_index2   = '0;
    rf_w_data   = '0;
    rf_w_enable = 1'b0;
    if (rst_n && rd_go) begin
      rd_ready  = 1'b1;
      rf_index1 = rd_idx_a;
      rf_index2 = rd_idx_b;
    end else if (wr_go) begin
      rf_index1   = fifo_idx_q[rd_ptr_q];
      rf_w_data   = fifo_data_q[rd_ptr_q];
      rf_w_enable = 1'b1;
    end
  end

  // FIFO pointer/count next state; pointers wrap as DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Operand capture: forwarded data wins over reg_file when bypassing.
  always_comb begin
`ifdef RFPC_WB_BYPASS_EN
    op_a_d = hit_a ? fwd_a : rf_rdata1;
    op_b_d = hit_b ? fwd_b : rf_rdata2;
`else
    op_a_d = rf_rdata1;
    op_b_d = rf_rdata2;
`endif
  end

  // FIFO control state; reset discards everything pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents are only meaningful below cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]  <= wb_idx;
      fifo_data_q[wr_ptr_q] <= wb_data;
    end
  end

  // Operand registers: one-cycle valid pulse, data held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      op_valid_q <= rd_go;
      if (rd_go) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
      end
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;

endmodule

// File: tb/tb_reg_file_port_ctrl.sv
// Bench for reg_file_port_ctrl: behavioural reg_file attached to the DUT,
// plus a queue-based reference of the write-back buffer and register state.
module tb_reg_file_port_ctrl;
  localparam int DW = 16, IW = 5, DEPTH = 4;

  logic clk = 0, rst_n = 0;
  logic rd_valid = 0, rd_ready, op_valid, wb_valid = 0, wb_ready, rf_w_enable;
  logic [IW-1:0] rd_idx_a = 0, rd_idx_b = 0, wb_idx = 0, rf_index1, rf_index2;
  logic [DW-1:0] op_a, op_b, wb_data = 0, rf_w_data, rf_rdata1, rf_rdata2;
  logic [2:0] wb_count;

  reg_file_port_ctrl #(.DATA_W(DW), .IDX_W(IW), .WB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_idx(wb_idx), .wb_data(wb_data), .wb_count(wb_count),
    .rf_index1(rf_index1), .rf_index2(rf_index2), .rf_w_data(rf_w_data),
    .rf_w_enable(rf_w_enable), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2));

  always #5 clk = ~clk;

  // Register file seen by the DUT (not reset, like the real one).
  logic [DW-1:0] rf [32] = '{default: '0};
  always @(posedge clk) if (rf_w_enable) rf[rf_index1] <= rf_w_data;
  assign rf_rdata1 = rf[rf_index1];
  assign rf_rdata2 = rf[rf_index2];

  // Reference model state.
  logic [DW-1:0] mrf [32] = '{default: '0};
  int q_idx[$];
  logic [DW-1:0] q_dat[$];
  logic exp_opv = 0;
  logic [DW-1:0] exp_a = 0, exp_b = 0;
  logic granted;
  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive at posedge+1, check combinational outputs at negedge,
  // advance the model at posedge, check registered operands at posedge+1.
  task automatic cycle(input logic rv, input logic [IW-1:0] ia, input logic [IW-1:0] ib,
                       input logic wv, input logic [IW-1:0] wi, input logic [DW-1:0] wd);
    logic full, hz, rd_ok, wr, acc;
    logic [DW-1:0] na, nb;
    rd_valid = rv; rd_idx_a = ia; rd_idx_b = ib;
    wb_valid = wv; wb_idx = wi; wb_data = wd;
    @(negedge clk);
    full = (q_idx.size() == DEPTH);
    hz = 0;
    foreach (q_idx[k]) if (q_idx[k] == int'(ia) || q_idx[k] == int'(ib)) hz = 1;
`ifdef RFPC_WB_BYPASS_EN
    rd_ok = rv && !full;
`else
    rd_ok = rv && !full && !hz;
`endif
    wr  = !rd_ok && q_idx.size() > 0;
    acc = wv && !full;
    chk("rd_ready", rd_ready, rd_ok);
    chk("rf_w_enable", rf_w_enable, wr);
    chk("wb_ready", wb_ready, !full);
    chk("wb_count", wb_count, q_idx.size());
    if (wr) begin
      chk("wr_index1", rf_index1, q_idx[0]);
      chk("wr_data", rf_w_data, q_dat[0]);
      chk("wr_index2", rf_index2, 0);
    end else if (rd_ok) begin
      chk("rd_index1", rf_index1, ia);
      chk("rd_index2", rf_index2, ib);
    end else begin
      chk("idle_index1", rf_index1, 0);
    end
    na = mrf[ia]; nb = mrf[ib];
`ifdef RFPC_WB_BYPASS_EN
    foreach (q_idx[k]) begin
      if (q_idx[k] == int'(ia)) na = q_dat[k];
      if (q_idx[k] == int'(ib)) nb = q_dat[k];
    end
`endif
    @(posedge clk);
    if (wr) begin
      mrf[q_idx[0]] = q_dat[0];
      void'(q_idx.pop_front());
      void'(q_dat.pop_front());
    end
    if (acc) begin q_idx.push_back(int'(wi)); q_dat.push_back(wd); end
    exp_opv = rd_ok;
    if (rd_ok) begin exp_a = na; exp_b = nb; end
    granted = rd_ok;
    #1;
    chk("op_valid", op_valid, exp_opv);
    chk("op_a", op_a, exp_a);
    chk("op_b", op_b, exp_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_wb_count", wb_count, 0);
    chk("rst_wb_ready", wb_ready, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_rf_w_enable", rf_w_enable, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Preload r3, r7 and read them back
    cycle(0, 0, 0, 1, 3, 16'h1234);
    cycle(0, 0, 0, 1, 7, 16'hBEEF);
    idle(3);
    cycle(1, 3, 7, 0, 0, 0);
    chk("t1_granted", granted, 1);
    chk("t1_op_a", op_a, 16'h1234);
    chk("t1_op_b", op_b, 16'hBEEF);

    // Four write-backs with no reads, then drain
    for (int i = 1; i <= 4; i++) cycle(0, 0, 0, 1, IW'(i), DW'(i * 'h11));
    idle(4);
    for (int i = 1; i <= 4; i++) chk("t2_rf", rf[i], DW'(i * 'h11));

    // RAW hazard on r5
    cycle(0, 0, 0, 1, 5, 16'hAAAA);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 5, 0, 0, 0, 0);
      if (granted) break;
    end
    chk("t3_granted", granted, 1);
    chk("t3_op_a", op_a, 16'hAAAA);

    // Two buffered writes to r9, youngest must win
    cycle(1, 20, 21, 1, 9, 16'h0001);
    cycle(1, 20, 21, 1, 9, 16'h0002);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 9, 0, 0, 0);
      if (granted) break;
    end
    chk("t4_op_b", op_b, 16'h0002);
    idle(3);

    // Fill the FIFO while reads hold the bus, then keep reading
    for (int i = 0; i < 4; i++) cycle(1, 20, 21, 1, IW'(24 + i), DW'(16'hC000 + i));
    for (int i = 0; i < 6; i++) cycle(1, 20, 21, 1, IW'(28 + i), DW'(16'hD000 + i));
    idle(6);

    // Asynchronous reset with 3 entries pending
    cycle(1, 20, 21, 1, 10, 16'h5555);
    cycle(1, 20, 21, 1, 11, 16'h6666);
    cycle(1, 20, 21, 1, 12, 16'h7777);
    chk("t6_pending", wb_count, 3);
    rd_valid = 0; wb_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("t6_wb_count", wb_count, 0);
    chk("t6_w_enable", rf_w_enable, 0);
    chk("t6_op_valid", op_valid, 0);
    chk("t6_op_a", op_a, 0);
    q_idx.delete(); q_dat.delete();
    exp_opv = 0; exp_a = 0; exp_b = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    idle(4);
    chk("t6_r10", rf[10], mrf[10]);
    chk("t6_r12", rf[12], 0);

    // Randomized traffic over a small index range to provoke hazards
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), IW'($urandom_range(0, 7)), IW'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), IW'($urandom_range(0, 7)), DW'($urandom));
    idle(6);
    for (int i = 0; i < 8; i++) chk("final_rf", rf[i], mrf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_port_ctrl.md
Name: reg_file_port_ctrl

Overview:
- Initiator side of the 32x16 register file interface.
- The register file shares one index bus between port-1 reads and writes. This block time-multiplexes that bus between operand-read requests from decode and write-back requests from execute/memory.
- Write-backs are buffered in a small FIFO. Read-after-write hazards against buffered writes are detected and resolved.
- Sits between decode/writeback logic and reg_file; it is the only driver of reg_file's index, data and enable inputs.

Parameters:
- DATA_W, 16, register data width.
- IDX_W, 5, register index width (32 registers).
- WB_DEPTH, 4, write-back FIFO entries; power of two, >=2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_valid  in  1  operand-read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_idx_a  in  IDX_W  first operand index.
- rd_idx_b  in  IDX_W  second operand index.
- op_valid  out  1  operands valid (one-cycle pulse).
- op_a  out  DATA_W  first operand, registered.
- op_b  out  DATA_W  second operand, registered.
- wb_valid  in  1  write-back request valid.
- wb_ready  out  1  write-back accepted when wb_valid and wb_ready.
- wb_idx  in  IDX_W  destination register.
- wb_data  in  DATA_W  write data.
- wb_count  out  $clog2(WB_DEPTH)+1  entries currently buffered.
- rf_index1  out  IDX_W  to reg_file reg_index1 (read port 1 / write index).
- rf_index2  out  IDX_W  to reg_file reg_index2.
- rf_w_data  out  DATA_W  to reg_file w_data.
- rf_w_enable  out  1  to reg_file w_enable.
- rf_rdata1  in  DATA_W  from reg_file read_reg_data1.
- rf_rdata2  in  DATA_W  from reg_file read_reg_data2.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied and pending writes discarded; wb_count=0.
  - op_valid=0, op_a=op_b=0.
  - rd_ready=0, wb_ready=0, rf_w_enable=0.
  - After release, the first edge operates normally.
- Hazard: asserted when rd_valid and rd_idx_a or rd_idx_b equals the idx of any stored FIFO entry. A write accepted in the same cycle is not yet stored; the read is treated as older and returns the pre-write value.
- Per-cycle slot decision (combinational, priority order):
  1. WRITE if FIFO full.
  2. READ if rd_valid and no hazard.
  3. WRITE if FIFO non-empty.
  4. Otherwise IDLE.
- READ slot:
  - rf_index1=rd_idx_a, rf_index2=rd_idx_b, rf_w_enable=0, rf_w_data=0, rd_ready=1.
  - At the edge, op_a<=rf_rdata1 and op_b<=rf_rdata2; op_valid=1 for the following cycle only. Latency request-to-op_valid is 1 cycle.
- WRITE slot:
  - rf_index1=head idx, rf_w_data=head data, rf_w_enable=1, rf_index2=0, rd_ready=0.
  - Head pops at the edge.
- IDLE slot: rf_w_enable=0, rf_index1=rf_index2=0, rd_ready=0.
- Write-back FIFO:
  - wb_ready = rst_n && (wb_count<WB_DEPTH), based on registered count; a pop in the same cycle does not raise wb_ready.
  - Push and pop in the same cycle leave wb_count unchanged. Pointers wrap modulo WB_DEPTH.
  - Entries drain strictly in order; repeated writes to the same index all reach reg_file.
- op_a/op_b hold their values when op_valid=0.
- Index 0 is an ordinary register: no hard-wired zero, and hazards apply to it.

Optional Feature:
- Macro: RFPC_WB_BYPASS_EN.
- Defined: a hazard does not block READ. Each matching operand is forwarded from the youngest matching FIFO entry into op_a/op_b at the slot edge. Non-matching operands come from reg_file. Priority rule 1 (full FIFO forces WRITE) still applies.
- Undefined: a hazard blocks READ (rd_ready=0) until every matching entry has drained.

Test Plan:
- Reset, then preload via writes r3=0x1234 and r7=0xBEEF, drain; read a=3, b=7 -> rd_ready=1, next cycle op_valid=1, op_a=0x1234, op_b=0xBEEF.
- Push 4 write-backs (r1..r4 = 0x0011..0x0044) with no reads -> wb_ready falls at wb_count=4; entries drain in order, one rf_w_enable pulse per cycle, r1..r4 hold the expected values.
- Push r5=0xAAAA, then read a=5 next cycle:
  - Without macro: rd_ready=0 until the write drains, then op_a=0xAAAA.
  - With RFPC_WB_BYPASS_EN: rd_ready=1 immediately and op_a=0xAAAA.
- Push r9=0x0001 then r9=0x0002, read b=9 with bypass -> op_b=0x0002 (youngest entry); without bypass -> op_b=0x0002 after both drain.
- FIFO full with rd_valid held (no hazard) -> a WRITE slot is taken first, then READ is granted; the read never waits more than one cycle per full condition.
- Assert rst_n low with 3 entries pending -> wb_count=0, rf_w_enable=0 immediately; no further writes reach reg_file after reset release.
